multi_gate_occupancy: RTL and testbench

//  Next-generation parking occupancy core: NUM_GATES independent two-sensor gates feed one shared,

---
 rtl/multi_gate_occupancy.sv | 173 +++++++++++++++++
 tb/tb_multi_gate_occupancy.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_gate_occupancy.sv
// Parking occupancy core: per-gate two-sensor direction FSMs feeding one
// saturating occupancy counter shared by all gates.
// Ports: clk, reset (sync, active high), a/b sensors per gate, clr_err,
//   enter_p/exit_p per-gate pulses, occupancy, full, empty, sat_err.
// Optional: define TOTAL_CNT_EN to add total_in[15:0], a wrapping
//   count of all completed entries (clamped ones included).
module multi_gate_occupancy #(
  parameter int NUM_GATES = 2,
  parameter int CAP       = 200,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] a,
  input  logic [NUM_GATES-1:0] b,
  input  logic                 clr_err,
  output logic [NUM_GATES-1:0] enter_p,
  output logic [NUM_GATES-1:0] exit_p,
  output logic [CNT_W-1:0]     occupancy,
  output logic                 full,
  output logic                 empty,
  output logic                 sat_err
`ifdef TOTAL_CNT_EN
  ,
  output logic [15:0]          total_in
`endif
);

  localparam int DW = CNT_W + 2;
  localparam logic signed [DW-1:0] CAP_S = DW'(CAP);

  typedef enum logic [2:0] {
    IDLE, E1, E2, E3, X1, X2, X3
  } st_t;

  for (genvar g = 0; g < NUM_GATES; g++) begin : gate
    st_t        st;
    logic       ent_q;
    logic       ext_q;
    logic [1:0] ab;

    assign ab = {a[g], b[g]};

    always_ff @(posedge clk) begin
      if (reset) begin
        st    <= IDLE;
        ent_q <= 1'b0;
        ext_q <= 1'b0;
      end else begin
        ent_q <= 1'b0;
        ext_q <= 1'b0;
        unique case (st)
          IDLE:
            unique case (ab)
              2'b10:   st <= E1;
              2'b01:   st <= X1;
              default: st <= IDLE;
            endcase
          E1:
            unique case (ab)
              2'b10:   st <= E1;
              2'b11:   st <= E2;
              default: st <= IDLE;
            endcase
          E2:
            unique case (ab)
              2'b11:   st <= E2;
              2'b01:   st <= E3;
              2'b10:   st <= E1;
              default: st <= IDLE;
            endcase
          E3:
            unique case (ab)
              2'b01: st <= E3;
              2'b11: st <= E2;
              2'b00: begin
                st    <= IDLE;
                ent_q <= 1'b1;
              end
              default: st <= IDLE;
            endcase
          X1:
            unique case (ab)
              2'b01:   st <= X1;
              2'b11:   st <= X2;
              default: st <= IDLE;
            endcase
          X2:
            unique case (ab)
              2'b11:   st <= X2;
              2'b10:   st <= X3;
              2'b01:   st <= X1;
              default: st <= IDLE;
            endcase
          X3:
            unique case (ab)
              2'b10: st <= X3;
              2'b11: st <= X2;
              2'b00: begin
                st    <= IDLE;
                ext_q <= 1'b1;
              end
              default: st <= IDLE;
            endcase
          default: st <= IDLE;
        endcase
      end
    end

    assign enter_p[g] = ent_q;
    assign exit_p[g]  = ext_q;
  end

  function automatic logic [DW-1:0] popc(
    input logic [NUM_GATES-1:0] v
  );
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      r = r + DW'(v[i]);
    end
    return r;
  endfunction

  logic signed [DW-1:0] delta;
  logic signed [DW-1:0] sum;
  logic                 clamp_hi;
  logic                 clamp_lo;
  logic [CNT_W-1:0]     occ_nxt;

  // Entries and exits from different gates in one cycle net out
  // before the bound check, so only the net excess clamps.
  always_comb begin
    delta    = $signed(popc(enter_p) - popc(exit_p));
    sum      = $signed({2'b00, occupancy}) + delta;
    clamp_lo = sum[DW-1];
    clamp_hi = !sum[DW-1] && (sum > CAP_S);
    occ_nxt  = sum[CNT_W-1:0];
    if (clamp_hi) begin
      occ_nxt = CNT_W'(CAP);
    end else if (clamp_lo) begin
      occ_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= '0;
      sat_err   <= 1'b0;
    end else begin
      occupancy <= occ_nxt;
      if (clamp_hi || clamp_lo) begin
        sat_err <= 1'b1;
      end else if (clr_err) begin
        sat_err <= 1'b0;
      end
    end
  end

  assign full  = (occupancy == CNT_W'(CAP));
  assign empty = (occupancy == '0);

`ifdef TOTAL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      total_in <= '0;
    end else begin
      total_in <= total_in + 16'(popc(enter_p));
    end
  end
`endif

endmodule

// File: tb/tb_multi_gate_occupancy.sv
// Scoreboard bench for multi_gate_occupancy (2 gates, capacity 6).
// Driver queues expected pulses/count; monitor checks on each pulse.
module tb_multi_gate_occupancy;

  localparam int CAP = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] a;
  logic [1:0] b;
  logic       clr_err;
  logic [1:0] enter_p;
  logic [1:0] exit_p;
  logic [7:0] occupancy;
  logic       full;
  logic       empty;
  logic       sat_err;
`ifdef TOTAL_CNT_EN
  logic [15:0] total_in;
`endif

  multi_gate_occupancy #(
    .NUM_GATES(2),
    .CAP(CAP),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .a(a),
    .b(b),
    .clr_err(clr_err),
    .enter_p(enter_p),
    .exit_p(exit_p),
    .occupancy(occupancy),
    .full(full),
    .empty(empty),
    .sat_err(sat_err)
`ifdef TOTAL_CNT_EN
    ,
    .total_in(total_in)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] en;
    logic [1:0] ex;
    logic [7:0] occ;
    logic       sat;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] ab0,
                       input logic [1:0] ab1);
    a = {ab1[1], ab0[1]};
    b = {ab1[0], ab0[0]};
    tick();
  endtask

  // Full passages on gates selected by en (entry) / ex (exit),
  // all completing on the same edge.
  task automatic pass(input logic [1:0] en,
                      input logic [1:0] ex,
                      input logic [7:0] occ,
                      input logic       sat);
    logic [1:0] ent_v[4];
    logic [1:0] ext_v[4];
    logic [1:0] ab0;
    logic [1:0] ab1;
    exp_t       e;
    ent_v = '{2'b10, 2'b11, 2'b01, 2'b00};
    ext_v = '{2'b01, 2'b11, 2'b10, 2'b00};
    for (int s = 0; s < 4; s++) begin
      if (s == 3) begin
        e.en  = en;
        e.ex  = ex;
        e.occ = occ;
        e.sat = sat;
        q.push_back(e);
      end
      ab0 = en[0] ? ent_v[s] : (ex[0] ? ext_v[s] : 2'b00);
      ab1 = en[1] ? ent_v[s] : (ex[1] ? ext_v[s] : 2'b00);
      drive(ab0, ab1);
    end
    repeat (3) drive(2'b00, 2'b00);
  endtask

  // Monitor: every pulse must match the head of the queue, and the
  // count/flags one cycle later must match that entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && ((enter_p | exit_p) != 2'b00)) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: en=%b ex=%b", enter_p, exit_p);
        end else begin
          e = q.pop_front();
          chk("enter_p", 32'(enter_p), 32'(e.en));
          chk("exit_p", 32'(exit_p), 32'(e.ex));
          @(negedge clk);
          chk("occupancy", 32'(occupancy), 32'(e.occ));
          chk("full", 32'(full), 32'(e.occ == 8'(CAP)));
          chk("empty", 32'(empty), 32'(e.occ == 8'd0));
          chk("sat_err", 32'(sat_err), 32'(e.sat));
          chk("pulse_width", 32'(enter_p | exit_p), 32'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    a       = 2'b00;
    b       = 2'b00;
    clr_err = 1'b0;
    repeat (2) tick();
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_sat", 32'(sat_err), 32'd0);
    chk("rst_pulses", 32'(enter_p | exit_p), 32'd0);
`ifdef TOTAL_CNT_EN
    chk("rst_total", 32'(total_in), 32'd0);
`endif
    reset = 1'b0;
    tick();

    pass(2'b01, 2'b00, 8'd1, 1'b0);
    pass(2'b00, 2'b10, 8'd0, 1'b0);

    // backout on gate0
    drive(2'b10, 2'b00);
    drive(2'b11, 2'b00);
    drive(2'b10, 2'b00);
    drive(2'b00, 2'b00);
    repeat (2) tick();
    chk("backout_occ", 32'(occupancy), 32'd0);

    // exit while empty clamps at 0
    pass(2'b00, 2'b01, 8'd0, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_sat_lo", 32'(sat_err), 32'd0);

    pass(2'b11, 2'b00, 8'd2, 1'b0);
    pass(2'b11, 2'b00, 8'd4, 1'b0);
    pass(2'b01, 2'b00, 8'd5, 1'b0);
    pass(2'b01, 2'b10, 8'd5, 1'b0);
    pass(2'b01, 2'b00, 8'd6, 1'b0);
    pass(2'b01, 2'b00, 8'd6, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_sat_hi", 32'(sat_err), 32'd0);

    // clamp coinciding with clear: set wins
    clr_err = 1'b1;
    pass(2'b11, 2'b00, 8'd6, 1'b1);
    clr_err = 1'b0;
    chk("sat_cleared", 32'(sat_err), 32'd0);
`ifdef TOTAL_CNT_EN
    chk("total_in", 32'(total_in), 32'd11);
`endif
    pass(2'b00, 2'b01, 8'd5, 1'b0);

    // reset while gate0 is in E2
    drive(2'b10, 2'b00);
    drive(2'b11, 2'b00);
    reset = 1'b1;
    drive(2'b11, 2'b00);
    reset = 1'b0;
    drive(2'b01, 2'b00);
    drive(2'b00, 2'b00);
    repeat (3) tick();
    chk("midrst_occ", 32'(occupancy), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_sat", 32'(sat_err), 32'd0);
`ifdef TOTAL_CNT_EN
    chk("midrst_total", 32'(total_in), 32'd0);
`endif

    repeat (3) tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
